mac_job_sched: RTL and testbench

//  Shares one pipelined 16-bit MAC (2 input regs -> mult reg -> accumulator) between NREQ requesters.

---
 rtl/mac_job_sched_pkg.sv | 20 ++
 rtl/mac_job_sched_if.sv | 34 +++
 rtl/mac_job_sched_rr_arb.sv | 32 +++
 rtl/mac_job_sched.sv | 153 +++++++++++++++
 tb/tb_mac_job_sched.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_job_sched_pkg.sv
// Shared types and defaults for the MAC job scheduler and the MAC it feeds.
package mac_job_sched_pkg;

    localparam int NREQ_DEF    = 4;
    localparam int DW_DEF      = 16;
    localparam int LENW_DEF    = 8;
    localparam int MAC_LAT_DEF = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Requester id width; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mac_job_sched_if.sv
// Requester-side bus of the MAC job scheduler: job requests, operand stream, results.
interface mac_job_sched_if
    import mac_job_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int DW   = DW_DEF,
    parameter int LENW = LENW_DEF
) ();
    localparam int IDW = id_width(NREQ);

    logic [NREQ-1:0]      req_valid;
    logic [NREQ*LENW-1:0] req_len;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      in_valid;
    logic [NREQ*DW-1:0]   in_a;
    logic [NREQ*DW-1:0]   in_b;
    logic [NREQ-1:0]      in_ready;
    logic                 res_valid;
    logic [IDW-1:0]       res_id;
    logic [DW-1:0]        res_data;
    logic                 busy;

    // Requester engines side
    modport master (
        output req_valid, req_len, in_valid, in_a, in_b,
        input  req_ready, in_ready, res_valid, res_id, res_data, busy
    );

    // Scheduler side
    modport slave (
        input  req_valid, req_len, in_valid, in_a, in_b,
        output req_ready, in_ready, res_valid, res_id, res_data, busy
    );
endinterface

// File: rtl/mac_job_sched_rr_arb.sv
// Circular-priority picker: first set request strictly after ptr, wrapping around.
module mac_rr_arb
    import mac_job_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0]           req,
    input  logic [id_width(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]           gnt,
    output logic [id_width(NREQ)-1:0] idx,
    output logic                      any
);
    localparam int IDW = id_width(NREQ);

    // Scan ptr+1 .. ptr+NREQ (mod NREQ); the last slot is ptr itself.
    always_comb begin
        int j;
        j   = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!any && req[j]) begin
                gnt[j] = 1'b1;
                idx    = IDW'(j);
                any    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mac_job_sched.sv
// Time-shares one pipelined MAC between NREQ requesters. A job is a stream of
// operand pairs; the MAC is never cleared, so each job's sum is the difference
// between the accumulator after the job drains and its value before it.
// Build option: MAC_SCHED_PRIO0_EN gives requester 0 absolute priority.
module mac_job_sched
    import mac_job_sched_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int DW      = DW_DEF,
    parameter int LENW    = LENW_DEF,
    parameter int MAC_LAT = MAC_LAT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    mac_job_sched_if.slave bus,
    output logic [DW-1:0] mac_a,
    output logic [DW-1:0] mac_b,
    input  logic [DW-1:0] mac_acc
);
    localparam int IDW = id_width(NREQ);
    localparam int DCW = $clog2(MAC_LAT + 2);

    state_t          state, state_nxt;
    logic [IDW-1:0]  rr_ptr, id;
    logic [LENW-1:0] len, cnt;
    logic [DCW-1:0]  dcnt;
    logic [DW-1:0]   base;

    logic [NREQ-1:0] rr_gnt, win_gnt;
    logic [IDW-1:0]  rr_idx, win_idx;
    logic            rr_any, win_any, ptr_upd;
    logic [LENW-1:0] win_len;
    logic            sel_valid, accept, hs, drain_end;
    logic [DW-1:0]   sel_a, sel_b;

    mac_rr_arb #(.NREQ(NREQ)) u_arb (
        .req (bus.req_valid),
        .ptr (rr_ptr),
        .gnt (rr_gnt),
        .idx (rr_idx),
        .any (rr_any)
    );

`ifdef MAC_SCHED_PRIO0_EN
    // Requester 0 preempts the rotation and does not move the pointer.
    always_comb begin
        if (bus.req_valid[0]) begin
            win_gnt = NREQ'(1);
            win_idx = '0;
            win_any = 1'b1;
            ptr_upd = 1'b0;
        end else begin
            win_gnt = rr_gnt;
            win_idx = rr_idx;
            win_any = rr_any;
            ptr_upd = 1'b1;
        end
    end
`else
    assign win_gnt = rr_gnt;
    assign win_idx = rr_idx;
    assign win_any = rr_any;
    assign ptr_upd = 1'b1;
`endif

    // Length offered by the would-be winner, sampled only on accept.
    always_comb begin
        win_len = '0;
        for (int i = 0; i < NREQ; i++)
            if (win_idx == IDW'(i)) win_len = bus.req_len[i*LENW +: LENW];
    end

    // Operand lane of the active requester.
    always_comb begin
        sel_valid = 1'b0;
        sel_a     = '0;
        sel_b     = '0;
        for (int i = 0; i < NREQ; i++)
            if (id == IDW'(i)) begin
                sel_valid = bus.in_valid[i];
                sel_a     = bus.in_a[i*DW +: DW];
                sel_b     = bus.in_b[i*DW +: DW];
            end
    end

    assign drain_end = (state == DRAIN) && (dcnt == DCW'(MAC_LAT));

    // Next state and handshake strobes.
    always_comb begin
        state_nxt     = state;
        bus.req_ready = '0;
        bus.in_ready  = '0;
        accept        = 1'b0;
        hs            = 1'b0;
        unique case (state)
            IDLE: if (win_any) begin
                accept        = 1'b1;
                bus.req_ready = win_gnt;
                state_nxt     = (win_len == '0) ? DRAIN : RUN;
            end
            RUN: begin
                bus.in_ready[id] = 1'b1;
                hs               = sel_valid;
                if (hs && cnt == len - LENW'(1)) state_nxt = DRAIN;
            end
            DRAIN: if (drain_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nxt;

    // Job bookkeeping, MAC operand feed and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr        <= IDW'(NREQ - 1);
            id            <= '0;
            len           <= '0;
            cnt           <= '0;
            dcnt          <= '0;
            base          <= '0;
            mac_a         <= '0;
            mac_b         <= '0;
            bus.res_valid <= 1'b0;
            bus.res_id    <= '0;
            bus.res_data  <= '0;
        end else begin
            // Zero pairs keep the accumulator still while stalled or idle.
            mac_a         <= hs ? sel_a : '0;
            mac_b         <= hs ? sel_b : '0;
            bus.res_valid <= 1'b0;
            dcnt          <= (state == DRAIN) ? dcnt + DCW'(1) : '0;
            if (accept) begin
                len <= win_len;
                id  <= win_idx;
                cnt <= '0;
                if (ptr_upd) rr_ptr <= win_idx;
            end
            if (hs) cnt <= cnt + LENW'(1);
            if (drain_end) begin
                bus.res_data  <= mac_acc - base;
                bus.res_id    <= id;
                bus.res_valid <= 1'b1;
                base          <= mac_acc;
            end
        end
    end

    assign bus.busy = (state != IDLE);
endmodule

// File: tb/tb_mac_job_sched.sv
// Bench for mac_job_sched with a behavioural MAC, a transaction-level model
// (winner by circular priority, sum of products, fixed result latency),
// directed vector table, reset/arbitration sequences and random traffic.
module tb_mac_job_sched;
    localparam int NREQ = 4, DW = 16, LENW = 8, MAC_LAT = 3;
    localparam int RES_LAT = MAC_LAT + 2;

    logic clk = 1'b0;
    logic rst;
    logic [DW-1:0] mac_a, mac_b, mac_acc;

    mac_job_sched_if #(.NREQ(NREQ), .DW(DW), .LENW(LENW)) bus ();

    mac_job_sched #(.NREQ(NREQ), .DW(DW), .LENW(LENW), .MAC_LAT(MAC_LAT)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .mac_a   (mac_a),
        .mac_b   (mac_b),
        .mac_acc (mac_acc)
    );

    always #5 clk = ~clk;

    // MAC: input regs -> product reg -> accumulator, truncating to DW.
    logic [DW-1:0] ra, rb, prod, acc;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin ra <= '0; rb <= '0; prod <= '0; acc <= '0; end
        else begin ra <= mac_a; rb <= mac_b; prod <= ra * rb; acc <= acc + prod; end
    assign mac_acc = acc;

    int n_cmp = 0, n_bad = 0, cyc = 0;

    // Requester-side job sources.
    bit            pend[NREQ];
    int            plen[NREQ];
    logic [DW-1:0] opa[NREQ][64], opb[NREQ][64];
    bit            refill[NREQ];
    int            gap, wait_cnt;

    // Model state.
    int            mphase, mact, mlen, mcnt, mptr;
    logic [DW-1:0] msum, act_a[64], act_b[64];
    bit            pres;
    int            rdue, rid;
    logic [DW-1:0] rdata;
    int            glog[$];
    int            n_res, last_id;
    logic [DW-1:0] last_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] v);
        int j;
`ifdef MAC_SCHED_PRIO0_EN
        if (v[0]) return 0;
`endif
        for (int k = 1; k <= NREQ; k++) begin
            j = (mptr + k) % NREQ;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    function automatic int next_gap();
        return (gap >= 0) ? gap : int'($urandom_range(0, 2));
    endfunction

    task automatic new_job(input int r, input int len);
        for (int k = 0; k < 64; k++) begin
            opa[r][k] = DW'($urandom);
            opb[r][k] = DW'($urandom);
        end
        plen[r] = len;
        pend[r] = 1'b1;
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_valid[i]            = pend[i];
            bus.req_len[i*LENW +: LENW] = pend[i] ? LENW'(plen[i]) : LENW'($urandom);
            bus.in_valid[i]             = 1'($urandom);
            bus.in_a[i*DW +: DW]        = DW'($urandom);
            bus.in_b[i*DW +: DW]        = DW'($urandom);
        end
        if (mphase == 1) begin
            if (wait_cnt > 0) begin
                bus.in_valid[mact] = 1'b0;
                wait_cnt--;
            end else begin
                bus.in_valid[mact]         = 1'b1;
                bus.in_a[mact*DW +: DW]    = act_a[mcnt];
                bus.in_b[mact*DW +: DW]    = act_b[mcnt];
            end
        end
    endtask

    task automatic expect_result(input int r, input logic [DW-1:0] d);
        mphase = 2;
        pres   = 1'b1;
        rdue   = cyc + RES_LAT;
        rid    = r;
        rdata  = d;
    endtask

    // One clock: check outputs against the model, advance model, drive next inputs.
    task automatic cycle();
        logic [NREQ-1:0] one, exp_rr, exp_ir;
        logic [DW-1:0]   pa, pb;
        int w;
        one = 1;
        @(negedge clk);
        cyc++;
        if (mphase == 2 && cyc == rdue) mphase = 0;
        w      = (mphase == 0) ? pick(bus.req_valid) : -1;
        exp_rr = (w >= 0) ? (one << w) : '0;
        exp_ir = (mphase == 1) ? (one << mact) : '0;
        chk("req_ready", bus.req_ready, exp_rr);
        chk("in_ready", bus.in_ready, exp_ir);
        chk("busy", bus.busy, mphase != 0);
        chk("res_valid", bus.res_valid, pres && cyc == rdue);
        if (pres && cyc == rdue) begin
            chk("res_id", bus.res_id, rid);
            chk("res_data", bus.res_data, rdata);
            last_id   = int'(bus.res_id);
            last_data = bus.res_data;
            pres      = 1'b0;
            n_res++;
        end
        if (mphase == 1 && bus.in_valid[mact]) begin
            pa       = bus.in_a[mact*DW +: DW];
            pb       = bus.in_b[mact*DW +: DW];
            msum     = msum + DW'(pa * pb);
            mcnt++;
            wait_cnt = next_gap();
            if (mcnt == mlen) expect_result(mact, msum);
        end else if (w >= 0) begin
            glog.push_back(w);
            mact = w;
            mlen = plen[w];
            mcnt = 0;
            msum = '0;
            for (int k = 0; k < 64; k++) begin
                act_a[k] = opa[w][k];
                act_b[k] = opb[w][k];
            end
            pend[w] = 1'b0;
`ifdef MAC_SCHED_PRIO0_EN
            if (w != 0) mptr = w;
`else
            mptr = w;
`endif
            wait_cnt = next_gap();
            if (refill[w]) new_job(w, 1);
            if (mlen == 0) expect_result(w, '0);
            else           mphase = 1;
        end
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run_idle(input int maxc);
        int n;
        bit act;
        n = 0;
        do begin
            act = (mphase != 0) || pres;
            for (int i = 0; i < NREQ; i++) act |= pend[i];
            if (act) begin cycle(); n++; end
        end while (act && n < maxc);
        chk("idle_timeout", n >= maxc, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) begin pend[i] = 1'b0; refill[i] = 1'b0; end
        bus.req_valid = '0; bus.req_len = '0; bus.in_valid = '0;
        bus.in_a = '0; bus.in_b = '0;
        @(negedge clk);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_mac_ab", {mac_a, mac_b}, 0);
        chk("rst_res", {bus.res_id, bus.res_data}, 0);
        chk("rst_ready", {bus.req_ready, bus.in_ready}, 0);
        mphase = 0; mptr = NREQ - 1; pres = 1'b0; wait_cnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive();
    endtask

    typedef struct packed {
        logic [2:0]         rq;
        logic [7:0]         len;
        logic [2:0][DW-1:0] a;
        logic [2:0][DW-1:0] b;
        logic [1:0]         gp;
        logic [DW-1:0]      exp;
    } vec_t;

    vec_t tbl[7];
    int   n0, g0;
    bit   ok;

    initial begin
        tbl[0] = '{3'd0, 8'd3, {16'h1, 16'h4, 16'h2}, {16'h1, 16'h5, 16'h3}, 2'd0, 16'd27};
        tbl[1] = '{3'd2, 8'd0, {16'h0, 16'h0, 16'h0}, {16'h0, 16'h0, 16'h0}, 2'd0, 16'd0};
        tbl[2] = '{3'd1, 8'd2, {16'h0, 16'd3, 16'd10}, {16'h0, 16'd3, 16'd20}, 2'd3, 16'd209};
        tbl[3] = '{3'd1, 8'd2, {16'h0, 16'd3, 16'd10}, {16'h0, 16'd3, 16'd20}, 2'd0, 16'd209};
        tbl[4] = '{3'd3, 8'd2, {16'h0, 16'h100, 16'hFF}, {16'h0, 16'hFF, 16'hFF}, 2'd0, 16'hFD01};
        tbl[5] = '{3'd0, 8'd1, {16'h0, 16'h0, 16'd3}, {16'h0, 16'h0, 16'd7}, 2'd0, 16'd21};
        tbl[6] = '{3'd2, 8'd3, {16'd7, 16'h8000, 16'hFFFF}, {16'd9, 16'd2, 16'hFFFF}, 2'd1, 16'h0040};

        n_res = 0; gap = 0; mphase = 0; mact = 0; mcnt = 0;
        do_reset();

        // Directed vectors
        for (int v = 0; v < 7; v++) begin
            new_job(int'(tbl[v].rq), int'(tbl[v].len));
            for (int k = 0; k < 3; k++) begin
                opa[tbl[v].rq][k] = tbl[v].a[k];
                opb[tbl[v].rq][k] = tbl[v].b[k];
            end
            gap = int'(tbl[v].gp);
            n0  = n_res;
            drive();
            run_idle(200);
            chk("vec_count", n_res, n0 + 1);
            chk("vec_id", last_id, tbl[v].rq);
            chk("vec_data", last_data, tbl[v].exp);
        end

        // Reset in the middle of a job, then a fresh job from a cleared base
        gap = 0;
        new_job(1, 5);
        drive();
        for (int n = 0; n < 50 && !(mphase == 1 && mcnt == 2); n++) cycle();
        chk("mid_job_reached", mphase == 1 && mcnt == 2, 1);
        do_reset();
        n0 = n_res;
        repeat (8) cycle();
        chk("no_res_after_rst", n_res, n0);
        new_job(0, 1);
        opa[0][0] = 16'd6; opb[0][0] = 16'd7;
        drive();
        run_idle(100);
        chk("post_rst_data", last_data, 16'd42);
        chk("post_rst_id", last_id, 0);

        // Two (then 0 and 3) requesters continuously valid with len=1 jobs
        for (int t = 0; t < 2; t++) begin
            int other;
            other = (t == 0) ? 1 : 3;
            do_reset();
            g0 = glog.size();
            refill[0] = 1'b1; refill[other] = 1'b1;
            new_job(0, 1); new_job(other, 1);
            drive();
            repeat (40) cycle();
            refill[0] = 1'b0; refill[other] = 1'b0;
            run_idle(100);
            chk("arb_njobs", glog.size() - g0 >= 6, 1);
            ok = 1'b1;
            for (int k = 0; k < 6; k++) begin
`ifdef MAC_SCHED_PRIO0_EN
                if (glog[g0 + k] != 0) ok = 1'b0;
`else
                if (glog[g0 + k] != ((k % 2 == 0) ? 0 : other)) ok = 1'b0;
`endif
            end
            chk("arb_order", ok, 1);
        end

        // Random traffic: random lengths, stalls, withdrawals, junk on idle lanes
        gap = -1;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 99) < 8) new_job(i, int'($urandom_range(0, 6)));
                else if (pend[i] && $urandom_range(0, 99) < 2) pend[i] = 1'b0;
            end
            cycle();
        end
        run_idle(500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
